isodata_job_scheduler: RTL
==========================

// Module: isodata_job_scheduler
// PURPOSE
//   Shares one isodata clustering engine among NREQ requesters. A round-robin arbiter
//   grants the engine to one requester at a time and latches that requester's iteration
//   budget. The block then pulses the engine start, watches for engine done with a cycle
//   watchdog, and returns a done or timeout pulse to the owner.
//   It sits between the requester fabric and the engine's start/done/data-select controls.
// PARAMETERS
//   NREQ     4      number of requesters (2..8)
//   ITER_W   4      width of per-request iteration budget
//   TO_W     16     watchdog counter width
//   TIMEOUT  60000  max RUN cycles before abort (must be < 2**TO_W)
// PORTS
//   clk           in   1              clock, rising edge
//   rst           in   1              asynchronous, active-high reset
//   req           in   NREQ           level request per requester; held until job_done/job_timeout
//   req_max_iter  in   NREQ*ITER_W    per-requester iteration budget; slice i = requester i
//   grant         out  NREQ           one-hot; owner bit high from START through DONE/ABORT
//   job_done      out  NREQ           one-cycle pulse to owner on normal completion
//   job_timeout   out  NREQ           one-cycle pulse to owner on watchdog abort
//   eng_start     out  1              one-cycle start pulse to engine
//   eng_abort     out  1              one-cycle synchronous abort to engine (returns it to IDLE)
//   eng_sel       out  $clog2(NREQ)   owner index; steers engine x/y data mux; stable while granted
//   eng_max_iter  out  ITER_W         latched budget of owner; stable from START until next START
//   eng_done      in   1              engine completion pulse (>=1 cycle)
//   busy          out  1              high in any state except IDLE
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr pointer 0; watchdog 0. Reset mid-job aborts
//   silently. No job_done or job_timeout pulse is issued.
//   FSM states: IDLE, START, RUN, DONE, ABORT. All outputs are registered.
//   IDLE:
//     - Each edge samples req.
//     - Winner = first requester with req set, searching from rr pointer upward with wrap.
//     - If a winner exists, the same edge enters START and sets grant[w], eng_sel=w,
//       eng_max_iter=req_max_iter[w], eng_start=1, and watchdog=0.
//     - If no req bit is set, stay in IDLE.
//     - eng_done while in IDLE is ignored.
//   START (1 cycle):
//     - Next edge enters RUN and clears eng_start.
//     - eng_done is not sampled in START.
//   RUN:
//     - Watchdog increments by 1 each RUN cycle.
//     - If eng_done=1 at an edge, go to DONE and set job_done[owner]=1.
//     - Else if watchdog==TIMEOUT-1, go to ABORT and set eng_abort=1 and job_timeout[owner]=1.
//     - eng_done and watchdog expiry on the same edge: done wins, no abort.
//   DONE / ABORT (1 cycle each):
//     - Next edge enters IDLE and clears grant, the owner pulse and eng_abort.
//     - rr pointer = (owner+1) mod NREQ.
//   Latency: req seen in IDLE -> eng_start 1 cycle later.
//     eng_done -> job_done 1 cycle later.
//     job_done -> earliest next eng_start 2 cycles later (DONE, then IDLE sample).
//   Requester contract: drop req on the edge after seeing job_done or job_timeout; the
//     next IDLE sample then excludes it.
//   Mid-job changes: req deassertion or req_max_iter change during START/RUN has no
//     effect; the job runs to done or timeout.
//   Fairness: with all req held high, grants rotate 0,1,..,NREQ-1,0. No requester waits
//     more than NREQ-1 jobs.
//   Invariants: grant is one-hot or zero; eng_sel and eng_max_iter change only on entry
//     to START.
// TESTING
//   1. Single job: req=0001, budget 5, eng_done 20 cycles after eng_start
//      -> grant=0001, eng_max_iter=5, job_done[0] 1 cycle after eng_done, busy low 2 cycles later.
//   2. Contention: req=1111 held throughout, rr=0
//      -> grant order 0,1,2,3,0; eng_sel tracks the grant; exactly one eng_start per job.
//   3. Timeout: TIMEOUT=100, eng_done never asserted
//      -> eng_abort and job_timeout[owner] pulse on cycle 100 of RUN; rr advances.
//   4. Race: eng_done asserted on the same edge as watchdog expiry
//      -> job_done pulses, no eng_abort, no job_timeout.
//   5. Reset mid-RUN: assert rst 7 cycles after eng_start
//      -> all outputs 0 immediately; next grant after release goes to requester 0.
//   6. Stray/late inputs: eng_done pulsed in IDLE, then req[2] dropped during RUN
//      -> stray done ignored; job 2 still completes with job_done[2].

Source files
------------

// File: rtl/isodata_job_scheduler.sv
// Round-robin job scheduler that time-shares one isodata clustering engine among NREQ
// requesters, with a RUN-cycle watchdog that aborts hung jobs.
module isodata_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int ITER_W  = 4,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 60000,
  localparam int SEL_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ITER_W-1:0] req_max_iter,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        job_done,
  output logic [NREQ-1:0]        job_timeout,
  output logic                   eng_start,
  output logic                   eng_abort,
  output logic [SEL_W-1:0]       eng_sel,
  output logic [ITER_W-1:0]      eng_max_iter,
  input  logic                   eng_done,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, START, RUN, DONE, ABORT} state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    rr_reg, rr_next;
  logic [TO_W-1:0]     wd_reg, wd_next;
  logic [NREQ-1:0]     grant_reg, grant_next;
  logic [NREQ-1:0]     job_done_reg, job_done_next;
  logic [NREQ-1:0]     job_timeout_reg, job_timeout_next;
  logic                eng_start_reg, eng_start_next;
  logic                eng_abort_reg, eng_abort_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [ITER_W-1:0]   max_iter_reg, max_iter_next;
  logic                busy_reg, busy_next;

  // Round-robin search: first requester at or above rr_reg, wrapping past NREQ-1.
  logic                found;
  logic [SEL_W-1:0]    win;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_next          = rr_reg;
    wd_next          = wd_reg;
    grant_next       = grant_reg;
    sel_next         = sel_reg;
    max_iter_next    = max_iter_reg;
    job_done_next    = '0;
    job_timeout_next = '0;
    eng_start_next   = 1'b0;
    eng_abort_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = START;
          grant_next     = NREQ'(1) << win;
          sel_next       = win;
          max_iter_next  = req_max_iter[int'(win)*ITER_W +: ITER_W];
          eng_start_next = 1'b1;
          wd_next        = '0;
        end
      end
      START: state_next = RUN;
      RUN: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (eng_done) begin
          state_next    = DONE;
          job_done_next = grant_reg;
        end else if (wd_reg == TO_W'(TIMEOUT - 1)) begin
          state_next       = ABORT;
          eng_abort_next   = 1'b1;
          job_timeout_next = grant_reg;
        end else begin
          wd_next = wd_reg + TO_W'(1);
        end
      end
      DONE, ABORT: begin
        state_next = IDLE;
        grant_next = '0;
        rr_next    = (sel_reg == SEL_W'(NREQ - 1)) ? '0 : sel_reg + SEL_W'(1);
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_reg          <= '0;
      wd_reg          <= '0;
      grant_reg       <= '0;
      job_done_reg    <= '0;
      job_timeout_reg <= '0;
      eng_start_reg   <= 1'b0;
      eng_abort_reg   <= 1'b0;
      sel_reg         <= '0;
      max_iter_reg    <= '0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_reg          <= rr_next;
      wd_reg          <= wd_next;
      grant_reg       <= grant_next;
      job_done_reg    <= job_done_next;
      job_timeout_reg <= job_timeout_next;
      eng_start_reg   <= eng_start_next;
      eng_abort_reg   <= eng_abort_next;
      sel_reg         <= sel_next;
      max_iter_reg    <= max_iter_next;
      busy_reg        <= busy_next;
    end
  end

  assign grant        = grant_reg;
  assign job_done     = job_done_reg;
  assign job_timeout  = job_timeout_reg;
  assign eng_start    = eng_start_reg;
  assign eng_abort    = eng_abort_reg;
  assign eng_sel      = sel_reg;
  assign eng_max_iter = max_iter_reg;
  assign busy         = busy_reg;

endmodule
